shift_unit: RTL

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_step.sv | 35 +++
 rtl/shift_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shifter.
// Rotate support is built only with SHIFT_UNIT_ROR_EN.
package shift_pkg;

  localparam logic [1:0] OPC_LSL = 2'd0;
  localparam logic [1:0] OPC_LSR = 2'd1;
  localparam logic [1:0] OPC_ASR = 2'd2;
  localparam logic [1:0] OPC_ROR = 2'd3;

  typedef enum logic [1:0] {
    LSL = OPC_LSL,
    LSR = OPC_LSR,
    ASR = OPC_ASR,
    ROR = OPC_ROR
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift slice of 0..STEP bit positions.
// The ROR path exists only with SHIFT_UNIT_ROR_EN.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int STEP  = 4,
  parameter int AW    = $clog2(STEP) + 1
) (
  input  shift_op_e          op,
  input  logic               fill,
  input  logic [AW-1:0]      amt,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout
);

  logic [WIDTH-1:0] ones;
  assign ones = '1;

  always_comb begin
    dout = din;
    unique case (op)
      LSL: dout = din << amt;
      LSR: dout = din >> amt;
      ASR: dout = (din >> amt)
                | (~(ones >> amt) & {WIDTH{fill}});
`ifdef SHIFT_UNIT_ROR_EN
      ROR: dout = (din >> amt)
                | (din << (WIDTH - int'(amt)));
`endif
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Iterative shifter: STEP bits per cycle, valid/ready on both sides.
// SHIFT_UNIT_ROR_EN enables op 3 (rotate right); otherwise it errors.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int STEP    = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err
);

  localparam int AW = $clog2(STEP) + 1;

  shift_state_e       state_q, state_d;
  shift_op_e          op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               fill_q, fill_d;
  logic               err_q, err_d;
  logic [AW-1:0]      amt;
  logic [WIDTH-1:0]   step_out;

  always_comb begin
    amt = AW'(rem_q);
    if ({1'b0, rem_q} > (SHAMT_W+1)'(STEP))
      amt = AW'(STEP);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AW    (AW)
  ) u_step (
    .op   (op_q),
    .fill (fill_q),
    .amt  (amt),
    .din  (work_q),
    .dout (step_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= LSL;
      work_q  <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = shift_op_e'(op);
          work_d = in_data;
          fill_d = in_data[WIDTH-1];
          rem_d  = shamt;
          err_d  = 1'b0;
`ifndef SHIFT_UNIT_ROR_EN
          // Unsupported rotate completes at once, operand untouched
          if (op == OPC_ROR) begin
            rem_d = '0;
            err_d = 1'b1;
          end
`endif
          state_d = (rem_d == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        work_d = step_out;
        rem_d  = rem_q - SHAMT_W'(amt);
        if (rem_d == '0)
          state_d = DONE;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) & reset;
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? work_q : '0;
  assign out_err   = out_valid & err_q;

endmodule
